// File: rtl/page_pkg.sv
// Shared constants and FSM state type for the image page window fetcher.
package page_pkg;

    localparam int unsigned IMG_W  = 640;
    localparam int unsigned IMG_H  = 640;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CRD_W  = 10;
    localparam int unsigned KTAPS  = 9;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

endpackage

// File: rtl/page_window_fetcher_if.sv
// Loader, conv-engine and page-RAM signals of the window fetcher.
interface page_window_fetcher_if #(
    parameter int unsigned ADDR_W = page_pkg::ADDR_W,
    parameter int unsigned DATA_W = page_pkg::DATA_W,
    parameter int unsigned CRD_W  = page_pkg::CRD_W
);

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              win_valid;
    logic              win_ready;
    logic [CRD_W-1:0]  win_row;
    logic [CRD_W-1:0]  win_col;
    logic              win_err;

    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic [3:0]        pix_idx;
    logic              pix_last;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  win_valid, win_row, win_col,
        input  mem_rdata,
        output wr_ready, win_ready, win_err,
        output pix_valid, pix_data, pix_idx, pix_last, busy,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output win_valid, win_row, win_col,
        output mem_rdata,
        input  wr_ready, win_ready, win_err,
        input  pix_valid, pix_data, pix_idx, pix_last, busy,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/page_window_fetcher_tap_addr_gen.sv
// Walks the nine 3x3 taps in raster order: tap index, bounds check and running page address.
module tap_addr_gen #(
    parameter int unsigned IMG_W  = page_pkg::IMG_W,
    parameter int unsigned IMG_H  = page_pkg::IMG_H,
    parameter int unsigned ADDR_W = page_pkg::ADDR_W,
    parameter int unsigned CRD_W  = page_pkg::CRD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CRD_W-1:0]  row_i,
    input  logic [CRD_W-1:0]  col_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [3:0]        k_o,
    output logic              inb_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);
    import page_pkg::*;

    logic [3:0]        k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        dr_sel, dc_sel;
    logic              row_ok, col_ok;

    always_comb begin
        // dr_sel/dc_sel: 0 -> -1, 1 -> 0, 2 -> +1
        if (k_q >= 4'd6) begin
            dr_sel = 2'd2;
            dc_sel = 2'(k_q - 4'd6);
        end else if (k_q >= 4'd3) begin
            dr_sel = 2'd1;
            dc_sel = 2'(k_q - 4'd3);
        end else begin
            dr_sel = 2'd0;
            dc_sel = k_q[1:0];
        end

        row_ok = !((dr_sel == 2'd0 && row_i == '0) ||
                   (dr_sel == 2'd2 && 32'(row_i) == IMG_H - 1));
        col_ok = !((dc_sel == 2'd0 && col_i == '0) ||
                   (dc_sel == 2'd2 && 32'(col_i) == IMG_W - 1));
        inb_o  = row_ok && col_ok;
        last_o = (32'(k_q) == KTAPS - 1);
        addr_o = (k_q == '0) ? base_i : addr_q;

        k_d    = '0;
        addr_d = addr_q;
        if (run) begin
            k_d    = last_o ? '0 : k_q + 4'd1;
            // stepping past the right column jumps to the left column of the next row
            addr_d = addr_o + ((dc_sel == 2'd2) ? ADDR_W'(IMG_W - 2) : ADDR_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q    <= '0;
            addr_q <= '0;
        end else begin
            k_q    <= k_d;
            addr_q <= addr_d;
        end
    end

    assign k_o = k_q;

endmodule

// File: rtl/page_window_fetcher.sv
// Arbitrates the single page port between loader writes and 3x3 window reads,
// and streams each window as nine zero-padded pixels.
module page_window_fetcher #(
    parameter int unsigned IMG_W  = page_pkg::IMG_W,
    parameter int unsigned IMG_H  = page_pkg::IMG_H,
    parameter int unsigned ADDR_W = page_pkg::ADDR_W,
    parameter int unsigned DATA_W = page_pkg::DATA_W,
    parameter int unsigned CRD_W  = page_pkg::CRD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    page_window_fetcher_if.slave  bus
);
    import page_pkg::*;

    state_t            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [CRD_W-1:0]  row_q, row_d;
    logic [CRD_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              win_err_q, win_err_d;
    logic              p1_valid_q, p1_valid_d;
    logic              p1_pad_q, p1_pad_d;
    logic [3:0]        p1_idx_q, p1_idx_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [3:0]        pix_idx_q, pix_idx_d;
    logic              pix_last_q, pix_last_d;

    logic              wr_grant, win_grant, win_oob;
    logic [ADDR_W-1:0] base_calc;
    logic [3:0]        tap_k;
    logic              tap_inb, tap_last;
    logic [ADDR_W-1:0] tap_addr;

    tap_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .CRD_W  (CRD_W)
    ) u_tap (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == FETCH),
        .row_i  (row_q),
        .col_i  (col_q),
        .base_i (base_q),
        .k_o    (tap_k),
        .inb_o  (tap_inb),
        .last_o (tap_last),
        .addr_o (tap_addr)
    );

    always_comb begin
        win_oob   = (32'(bus.win_row) >= IMG_H) || (32'(bus.win_col) >= IMG_W);
        // wraps for row 0 / col 0; only in-bounds taps ever use the result
        base_calc = ADDR_W'(bus.win_row) * ADDR_W'(IMG_W) + ADDR_W'(bus.win_col)
                    - ADDR_W'(IMG_W + 1);

        wr_grant  = 1'b0;
        win_grant = 1'b0;
        if (state_q == IDLE && rst) begin
            wr_grant  = bus.wr_valid && (!bus.win_valid || !last_wr_q);
            win_grant = bus.win_valid && !wr_grant;
        end
        bus.wr_ready  = wr_grant;
        bus.win_ready = win_grant;

        state_d       = state_q;
        last_wr_d     = last_wr_q;
        row_d         = row_q;
        col_d         = col_q;
        base_d        = base_q;
        win_err_d     = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        if (wr_grant) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wdata = bus.wr_data;
            last_wr_d     = 1'b1;
        end

        if (win_grant) begin
            last_wr_d = 1'b0;
            if (win_oob) begin
                win_err_d = 1'b1;
            end else begin
                row_d   = bus.win_row;
                col_d   = bus.win_col;
                base_d  = base_calc;
                state_d = FETCH;
            end
        end

        if (state_q == FETCH) begin
            if (tap_inb) begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = tap_addr;
            end
            if (tap_last) state_d = IDLE;
        end

        p1_valid_d  = (state_q == FETCH);
        p1_pad_d    = !tap_inb;
        p1_idx_d    = (state_q == FETCH) ? tap_k : '0;

        pix_valid_d = p1_valid_q;
        pix_data_d  = (p1_valid_q && !p1_pad_q) ? bus.mem_rdata : '0;
        pix_idx_d   = p1_valid_q ? p1_idx_q : '0;
        pix_last_d  = p1_valid_q && (32'(p1_idx_q) == KTAPS - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_wr_q   <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            base_q      <= '0;
            win_err_q   <= 1'b0;
            p1_valid_q  <= 1'b0;
            p1_pad_q    <= 1'b0;
            p1_idx_q    <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_idx_q   <= '0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            win_err_q   <= win_err_d;
            p1_valid_q  <= p1_valid_d;
            p1_pad_q    <= p1_pad_d;
            p1_idx_q    <= p1_idx_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_idx_q   <= pix_idx_d;
            pix_last_q  <= pix_last_d;
        end
    end

    assign bus.win_err   = win_err_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_idx   = pix_idx_q;
    assign bus.pix_last  = pix_last_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
